// File: rtl/loader_pkg.sv
// Shared constants and types for the program loader: stream widths and FSM state codes.
package loader_pkg;

    localparam int unsigned LOADER_ADR_WIDTH = 16;
    localparam int unsigned LOADER_BYTE_W    = 8;
    localparam int unsigned LOADER_WORD_W    = 32;
    localparam int unsigned LOADER_CNT_W     = 16;
    localparam int unsigned LOADER_STATE_W   = 3;

    localparam logic [LOADER_STATE_W-1:0] ST_CNT_HI = 3'd0;
    localparam logic [LOADER_STATE_W-1:0] ST_CNT_LO = 3'd1;
    localparam logic [LOADER_STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [LOADER_STATE_W-1:0] ST_WRITE  = 3'd3;
    localparam logic [LOADER_STATE_W-1:0] ST_CHECK  = 3'd4;
    localparam logic [LOADER_STATE_W-1:0] ST_DONE   = 3'd5;
    localparam logic [LOADER_STATE_W-1:0] ST_ERROR  = 3'd6;

    typedef logic [LOADER_BYTE_W-1:0]  stream_byte_t;
    typedef logic [LOADER_WORD_W-1:0]  pm_word_t;
    typedef logic [LOADER_CNT_W-1:0]   word_cnt_t;
    typedef logic [LOADER_STATE_W-1:0] loader_state_t;

    // States in which the loader accepts a stream byte
    function automatic logic is_ready_state(input loader_state_t st);
        return (st == ST_CNT_HI) || (st == ST_CNT_LO) || (st == ST_DATA) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/loader_if.sv
// Byte-stream input, program-memory write port and status lines of the program loader.
interface loader_if #(
    parameter int unsigned ADR_WIDTH = loader_pkg::LOADER_ADR_WIDTH
);
    loader_pkg::stream_byte_t byte_data;
    logic                     byte_valid;
    logic                     byte_ready;
    logic                     start;
    logic [ADR_WIDTH-1:0]     pm_wadr;
    loader_pkg::pm_word_t     pm_wdata;
    logic                     pm_wenable;
    logic                     cpu_hold;
    logic                     done;
    logic                     error;

    modport master (
        output byte_data, byte_valid, start,
        input  byte_ready, pm_wadr, pm_wdata, pm_wenable, cpu_hold, done, error
    );

    modport slave (
        input  byte_data, byte_valid, start,
        output byte_ready, pm_wadr, pm_wdata, pm_wenable, cpu_hold, done, error
    );
endinterface

// File: rtl/word_assembler.sv
// Shifts stream bytes MSB-first into a 32-bit word; flags the 4th byte of each word.
module word_assembler
    import loader_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         shift_en,
    input  stream_byte_t byte_in,
    output pm_word_t     word,
    output logic         word_ready_c
);

    logic [1:0] byte_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[LOADER_WORD_W-LOADER_BYTE_W-1:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_ready_c = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a counted word image from a byte stream into program memory while holding the CPU.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = LOADER_ADR_WIDTH
) (
    input logic     clock,
    input logic     reset_n,
    loader_if.slave lif
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t ST_LAST = ST_CHECK;
`else
    localparam loader_state_t ST_LAST = ST_DONE;
`endif

    loader_state_t        state, state_nxt;
    logic [ADR_WIDTH-1:0] adr, adr_nxt;
    word_cnt_t            wcnt, wcnt_nxt;
    word_cnt_t            n_words, n_words_nxt;
    logic                 ready_q, hold_q, done_q, wen_q;
    logic                 xfer_c, asm_en_c, clear_c, word_ready_c;
    pm_word_t             asm_word;

    assign xfer_c   = lif.byte_valid && ready_q;
    assign asm_en_c = xfer_c && (state == ST_DATA);

    word_assembler u_asm (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear_c),
        .shift_en     (asm_en_c),
        .byte_in      (lif.byte_data),
        .word         (asm_word),
        .word_ready_c (word_ready_c)
    );

`ifdef LOADER_CHECKSUM_EN
    stream_byte_t csum;
    logic         err_q;

    // Running XOR of data bytes only; count bytes never reach the assembler
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      csum <= '0;
        else if (clear_c)  csum <= '0;
        else if (asm_en_c) csum <= csum ^ lif.byte_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= (state_nxt == ST_ERROR);
    end

    assign lif.error = err_q;
`else
    assign lif.error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CNT_HI;
            adr     <= '0;
            wcnt    <= '0;
            n_words <= '0;
        end else begin
            state   <= state_nxt;
            adr     <= adr_nxt;
            wcnt    <= wcnt_nxt;
            n_words <= n_words_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        adr_nxt     = adr;
        wcnt_nxt    = wcnt;
        n_words_nxt = n_words;
        clear_c     = 1'b0;
        case (state)
            ST_CNT_HI: if (xfer_c) begin
                n_words_nxt = {lif.byte_data, LOADER_BYTE_W'(0)};
                state_nxt   = ST_CNT_LO;
            end
            ST_CNT_LO: if (xfer_c) begin
                n_words_nxt = {n_words[LOADER_CNT_W-1:LOADER_BYTE_W], lif.byte_data};
                state_nxt   = (n_words_nxt == '0) ? ST_LAST : ST_DATA;
            end
            ST_DATA: if (word_ready_c) state_nxt = ST_WRITE;
            ST_WRITE: begin
                adr_nxt   = adr + ADR_WIDTH'(1);
                wcnt_nxt  = wcnt + LOADER_CNT_W'(1);
                state_nxt = (wcnt_nxt == n_words) ? ST_LAST : ST_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: if (xfer_c) begin
                state_nxt = (lif.byte_data == csum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE, ST_ERROR:
`else
            ST_DONE:
`endif
            if (lif.start) begin
                state_nxt = ST_CNT_HI;
                adr_nxt   = '0;
                wcnt_nxt  = '0;
                clear_c   = 1'b1;
            end
            default: state_nxt = ST_CNT_HI;
        endcase
    end

    // Status outputs registered from the next state so they line up with the state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            ready_q <= is_ready_state(state_nxt);
            hold_q  <= (state_nxt != ST_DONE);
            done_q  <= (state_nxt == ST_DONE);
            wen_q   <= (state_nxt == ST_WRITE);
        end
    end

    assign lif.byte_ready = ready_q;
    assign lif.cpu_hold   = hold_q;
    assign lif.done       = done_q;
    assign lif.pm_wenable = wen_q;
    assign lif.pm_wadr    = adr;
    assign lif.pm_wdata   = asm_word;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader; checksum cases are built when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
    import loader_pkg::*;

    localparam int unsigned AW = 16;

    logic clock;
    logic reset_n;

    loader_if #(.ADR_WIDTH(AW)) lif ();

    program_loader #(.ADR_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .lif     (lif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0]  exp_q[$];
    logic [31:0]  img[$];
    logic [15:0]  exp_adr;
    logic [7:0]   exp_csum;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write
    always @(negedge clock) begin
        if (lif.pm_wenable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("extra_write", 64'(lif.pm_wadr), 64'hFFFF_FFFF);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                check_val("wr_adr",  64'(lif.pm_wadr),  64'(e[47:32]));
                check_val("wr_data", 64'(lif.pm_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic gap);
        int guard;
        guard = 0;
        lif.byte_data  = b;
        lif.byte_valid = 1'b1;
        while (lif.byte_ready !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) check_val("ready_timeout", 64'(guard), 64'd0);
        @(negedge clock);
        lif.byte_valid = 1'b0;
        if (gap) @(negedge clock);
    endtask

    task automatic pulse_start();
        lif.start = 1'b1;
        @(negedge clock);
        lif.start = 1'b0;
    endtask

    task automatic load_image(input logic gap, input logic bad_csum, input logic poke_start);
        logic [15:0] n;
        logic [31:0] w;
        n        = 16'(img.size());
        exp_adr  = '0;
        exp_csum = '0;
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            exp_q.push_back({exp_adr, w});
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8], 1'b0);
                exp_csum = exp_csum ^ w[k*8 +: 8];
                if (k == 0) check_val("wr_latency", 64'(lif.pm_wenable), 64'd1);
                if (poke_start && i == 0 && k == 3) begin
                    pulse_start();
                    check_val("start_ignored_hold", 64'(lif.cpu_hold), 64'd1);
                    check_val("start_ignored_rdy",  64'(lif.byte_ready), 64'd1);
                end
                if (gap) @(negedge clock);
            end
            exp_adr = exp_adr + 16'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (exp_csum ^ 8'h01) : exp_csum, 1'b0);
`else
        if (bad_csum) check_val("bad_csum_unsupported", 64'd1, 64'd0);
`endif
    endtask

    task automatic wait_end();
        int guard;
        guard = 0;
        while (lif.done !== 1'b1 && lif.error !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check_val("end_timeout", 64'(guard < 200), 64'd1);
    endtask

    task automatic expect_done(input string tag);
        wait_end();
        check_val({tag, "_done"},  64'(lif.done),       64'd1);
        check_val({tag, "_hold"},  64'(lif.cpu_hold),   64'd0);
        check_val({tag, "_err"},   64'(lif.error),      64'd0);
        check_val({tag, "_rdy"},   64'(lif.byte_ready), 64'd0);
        check_val({tag, "_sb"},    64'(exp_q.size()),   64'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        lif.byte_data  = '0;
        lif.byte_valid = 1'b0;
        lif.start      = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_hold",  64'(lif.cpu_hold),   64'd1);
        check_val("rst_wen",   64'(lif.pm_wenable), 64'd0);
        check_val("rst_wadr",  64'(lif.pm_wadr),    64'd0);
        check_val("rst_wdata", 64'(lif.pm_wdata),   64'd0);
        check_val("rst_done",  64'(lif.done),       64'd0);
        check_val("rst_err",   64'(lif.error),      64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_val("rst_rdy",   64'(lif.byte_ready), 64'd1);

        // Single word image
        img = {32'hFC00_0FFF};
        load_image(1'b0, 1'b0, 1'b0);
        expect_done("one_word");

        // Three words with gapped valid; a start during DATA must be ignored
        pulse_start();
        img = {};
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        load_image(1'b1, 1'b0, 1'b1);
        expect_done("three_words");

        // Empty image
        pulse_start();
        img = {};
        load_image(1'b0, 1'b0, 1'b0);
        expect_done("empty");

        // Reset after the 2nd data byte abandons the word
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset_n = 1'b0;
        #1;
        check_val("midrst_wen",  64'(lif.pm_wenable), 64'd0);
        check_val("midrst_hold", 64'(lif.cpu_hold),   64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        img = {32'h0102_0304, 32'hA5A5_5A5A};
        load_image(1'b0, 1'b0, 1'b0);
        expect_done("after_rst");

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        img = {32'h1122_3344};
        load_image(1'b0, 1'b0, 1'b0);
        expect_done("csum_ok");

        pulse_start();
        img = {32'h1122_3344};
        load_image(1'b0, 1'b1, 1'b0);
        wait_end();
        check_val("csum_bad_err",  64'(lif.error),    64'd1);
        check_val("csum_bad_done", 64'(lif.done),     64'd0);
        check_val("csum_bad_hold", 64'(lif.cpu_hold), 64'd1);
        pulse_start();
        check_val("rearm_err", 64'(lif.error),      64'd0);
        check_val("rearm_rdy", 64'(lif.byte_ready), 64'd1);
`endif

        repeat (3) @(negedge clock);
        check_val("final_sb", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
